// File: rtl/snoop_bus_arbiter.sv
// Round-robin coherent bus arbiter: grant, snoop broadcast, memory access, completion.
// Optional memory wait timeout enabled by defining SNOOP_ARB_TIMEOUT_EN.
module snoop_bus_arbiter #(
  parameter int unsigned NUM_CPUS = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CPUS-1:0]        bus_request,
  input  logic [NUM_CPUS-1:0]        bus_rw,
  input  logic [NUM_CPUS*ADDR_W-1:0] req_addr,
  input  logic [NUM_CPUS*DATA_W-1:0] req_data,
  output logic [NUM_CPUS-1:0]        bus_grant,
  output logic                       snoop_valid,
  output logic [ADDR_W-1:0]          snoop_addr,
  output logic                       snoop_rw,
  output logic [NUM_CPUS-1:0]        invalidate,
  input  logic [NUM_CPUS-1:0]        snoop_hit,
  output logic                       shared,
  output logic                       mem_req,
  output logic                       mem_rw,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ready,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [DATA_W-1:0]          bus_rdata,
  output logic                       bus_done,
  output logic                       bus_err
);

  localparam int unsigned PtrW = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;

  typedef enum logic [2:0] {StIdle, StGrant, StSnoop, StMem, StDone} state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_CPUS-1:0]   grant_q, grant_d;
  logic [NUM_CPUS-1:0]   inval_q, inval_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  rw_q, rw_d;
  logic                  snoop_valid_q, snoop_valid_d;
  logic                  shared_q, shared_d;
  logic                  mem_req_q, mem_req_d;
  logic                  done_q, done_d;

  logic [PtrW-1:0]       pick;
  logic [NUM_CPUS-1:0]   pick_oh;
  logic                  found;
  int unsigned           cand;
  logic                  owner_req;

`ifdef SNOOP_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  logic [CntW-1:0] wait_q, wait_d;
  logic            err_q, err_d;
`endif

  // Owner's request is still present; losing it before MEM aborts the transaction.
  assign owner_req = |(bus_request & grant_q);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    inval_d       = '0;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rw_d          = rw_q;
    snoop_valid_d = 1'b0;
    shared_d      = shared_q;
    mem_req_d     = mem_req_q;
    done_d        = 1'b0;
`ifdef SNOOP_ARB_TIMEOUT_EN
    wait_d        = wait_q;
    err_d         = 1'b0;
`endif

    // Search upward from the slot after the last owner.
    pick  = rr_ptr_q;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= NUM_CPUS; k++) begin
      cand = (32'(rr_ptr_q) + k) % NUM_CPUS;
      if (!found && bus_request[PtrW'(cand)]) begin
        pick  = PtrW'(cand);
        found = 1'b1;
      end
    end
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          rr_ptr_d      = pick;
          grant_d       = pick_oh;
          addr_d        = req_addr[pick*ADDR_W +: ADDR_W];
          wdata_d       = req_data[pick*DATA_W +: DATA_W];
          rw_d          = bus_rw[pick];
          snoop_valid_d = 1'b1;
          inval_d       = bus_rw[pick] ? ~pick_oh : '0;
          state_d       = StGrant;
        end
      end
      StGrant: begin
        if (!owner_req) begin
          grant_d = '0;
          state_d = StIdle;
        end else begin
          state_d = StSnoop;
        end
      end
      StSnoop: begin
        if (!owner_req) begin
          grant_d = '0;
          state_d = StIdle;
        end else begin
          shared_d  = |(snoop_hit & ~grant_q);
          mem_req_d = 1'b1;
`ifdef SNOOP_ARB_TIMEOUT_EN
          wait_d    = '0;
`endif
          state_d   = StMem;
        end
      end
      StMem: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (!rw_q) rdata_d = mem_rdata;
          done_d    = 1'b1;
          state_d   = StDone;
        end
`ifdef SNOOP_ARB_TIMEOUT_EN
        else if (wait_q == CntW'(MAX_WAIT - 1)) begin
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          state_d   = StDone;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      StDone: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      rr_ptr_q      <= PtrW'(NUM_CPUS - 1);
      grant_q       <= '0;
      inval_q       <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      rw_q          <= 1'b0;
      snoop_valid_q <= 1'b0;
      shared_q      <= 1'b0;
      mem_req_q     <= 1'b0;
      done_q        <= 1'b0;
`ifdef SNOOP_ARB_TIMEOUT_EN
      wait_q        <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      inval_q       <= inval_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      rw_q          <= rw_d;
      snoop_valid_q <= snoop_valid_d;
      shared_q      <= shared_d;
      mem_req_q     <= mem_req_d;
      done_q        <= done_d;
`ifdef SNOOP_ARB_TIMEOUT_EN
      wait_q        <= wait_d;
      err_q         <= err_d;
`endif
    end
  end

  assign bus_grant   = grant_q;
  assign snoop_valid = snoop_valid_q;
  assign snoop_addr  = addr_q;
  assign snoop_rw    = rw_q;
  assign invalidate  = inval_q;
  assign shared      = shared_q;
  assign mem_req     = mem_req_q;
  assign mem_rw      = rw_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign bus_rdata   = rdata_q;
  assign bus_done    = done_q;
`ifdef SNOOP_ARB_TIMEOUT_EN
  assign bus_err     = err_q;
`else
  assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Randomized scoreboard bench for snoop_bus_arbiter; a round-robin/memory model predicts
// each transaction and a negedge monitor compares what the bus presents.
module tb_snoop_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    bus_request, bus_rw, bus_grant, invalidate, snoop_hit;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            snoop_valid, snoop_rw, shared, mem_req, mem_rw, mem_ready;
  logic            bus_done, bus_err;
  logic [AW-1:0]   snoop_addr, mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata, bus_rdata;

  always #5 clk = ~clk;

  snoop_bus_arbiter #(.NUM_CPUS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .bus_request(bus_request), .bus_rw(bus_rw),
    .req_addr(req_addr), .req_data(req_data), .bus_grant(bus_grant),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_rw(snoop_rw),
    .invalidate(invalidate), .snoop_hit(snoop_hit), .shared(shared), .mem_req(mem_req),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .bus_rdata(bus_rdata), .bus_done(bus_done), .bus_err(bus_err)
  );

  typedef struct {
    int          owner;
    bit          rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    bit          shared;
    bit          err;
    bit          abort;
    bit          b2b;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          ptr;
  logic [31:0] last_rd;
  logic [31:0] mmod[logic [31:0]];
  logic [31:0] rmem[logic [31:0]];
  bit          mem_hold = 1'b0;
  int          rsp_lat = -1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] init_val(logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int next_owner(logic [N-1:0] pend);
    for (int k = 1; k <= N; k++) begin
      int idx = (ptr + k) % N;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  // Memory responder: random latency, backing store shared with nothing in the model.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        rsp_lat   = -1;
      end else if (mem_req && !mem_hold && !reset) begin
        if (rsp_lat < 0) rsp_lat = $urandom_range(0, 3);
        if (rsp_lat == 0) begin
          mem_ready = 1'b1;
          mem_rdata = rmem.exists(mem_addr) ? rmem[mem_addr] : init_val(mem_addr);
          if (mem_rw) rmem[mem_addr] = mem_wdata;
        end else begin
          rsp_lat--;
        end
      end else begin
        rsp_lat = -1;
      end
    end
  end

  // Monitor
  exp_t         mon_e;
  logic [N-1:0] mon_oh, mon_inv;
  int           zc = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (snoop_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_snoop: got snoop_valid=1, expected no transaction");
        end else begin
          mon_e   = sb[0];
          mon_oh  = '0;
          mon_oh[mon_e.owner] = 1'b1;
          mon_inv = mon_e.rw ? ~mon_oh : '0;
          chk("grant_onehot", bus_grant, mon_oh);
          chk("snoop_addr", snoop_addr, mon_e.addr);
          chk("snoop_rw", snoop_rw, mon_e.rw);
          chk("invalidate", invalidate, mon_inv);
          if (mon_e.b2b) chk("idle_gap_cycles", zc, 1);
          if (mon_e.abort) void'(sb.pop_front());
        end
      end else if (invalidate != '0) begin
        checks++; errors++;
        $display("FAIL stray_invalidate: got 0x%h outside grant cycle, expected 0", invalidate);
      end
      if (bus_grant == '0) zc++;
      else zc = 0;

      if (mem_req && mem_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem: got mem_req=1, expected no transaction");
        end else begin
          mon_e = sb[0];
          chk("mem_addr", mem_addr, mon_e.addr);
          chk("mem_rw", mem_rw, mon_e.rw);
          if (mon_e.rw) chk("mem_wdata", mem_wdata, mon_e.data);
        end
      end

      if (bus_done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got bus_done=1, expected no transaction");
        end else begin
          mon_e  = sb.pop_front();
          mon_oh = '0;
          mon_oh[mon_e.owner] = 1'b1;
          chk("done_grant_held", bus_grant, mon_oh);
          chk("shared", shared, mon_e.shared);
          chk("bus_err", bus_err, mon_e.err);
          chk("bus_rdata", bus_rdata, mon_e.rdata);
        end
      end
    end
  end

  task automatic check_all_zero();
    chk("rst_ctrl_zero", {bus_grant, invalidate, snoop_valid, snoop_rw, shared, mem_req,
                          mem_rw, bus_done, bus_err}, 0);
    chk("rst_addr_zero", snoop_addr | mem_addr, 0);
    chk("rst_data_zero", mem_wdata | bus_rdata, 0);
  endtask

  // One round: a request set held until each cache's own transaction completes.
  task automatic run_round(input logic [N-1:0] req, input int gap);
    logic [31:0]  a[N];
    logic [31:0]  d[N];
    bit           w[N];
    logic [N-1:0] hit, pend, oh;
    int           order[$];
    int           o, k, cyc;
    exp_t         e;
    bit           first = 1'b1;
    hit = N'($urandom_range(0, 15));
    for (int i = 0; i < N; i++) begin
      w[i] = 1'($urandom_range(0, 1));
      a[i] = 32'h100 + 4 * $urandom_range(0, 7);
      d[i] = $urandom;
    end
    pend = req;
    while (pend != '0) begin
      o   = next_owner(pend);
      ptr = o;
      oh  = '0;
      oh[o] = 1'b1;
      e = '{owner: o, rw: w[o], addr: a[o], data: d[o], rdata: 0, shared: |(hit & ~oh),
            err: 0, abort: 0, b2b: !first};
      if (w[o]) mmod[a[o]] = d[o];
      else last_rd = mmod.exists(a[o]) ? mmod[a[o]] : init_val(a[o]);
      e.rdata = last_rd;
      sb.push_back(e);
      order.push_back(o);
      pend[o] = 1'b0;
      first = 1'b0;
    end
    repeat (gap) begin @(posedge clk); #1; end
    for (int i = 0; i < N; i++) begin
      bus_rw[i] = w[i];
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
    snoop_hit   = hit;
    bus_request = req;
    k   = 0;
    cyc = 0;
    while (k < order.size() && cyc < 60 * N) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1 && gap > 0) begin
        oh = '0;
        oh[order[0]] = 1'b1;
        chk("grant_latency", bus_grant, oh);
      end
      if (bus_done) begin
        bus_request[order[k]] = 1'b0;
        k++;
      end
    end
    if (k < order.size()) begin
      checks++; errors++;
      $display("FAIL round_timeout: got %0d completions, expected %0d", k, order.size());
      bus_request = '0;
      sb.delete();
    end
  endtask

  task automatic abort_txn(input int c, input bit in_grant);
    exp_t e;
    int   cyc, bad;
    e = '{owner: c, rw: 0, addr: 32'h200 + 4 * c, data: 0, rdata: 0, shared: 0, err: 0,
          abort: 1, b2b: 0};
    ptr = c;
    sb.push_back(e);
    bus_rw[c] = 1'b0;
    req_addr[c*AW +: AW] = e.addr;
    bus_request    = '0;
    bus_request[c] = 1'b1;
    cyc = 0;
    while (!snoop_valid && cyc < 10) begin @(posedge clk); #1; cyc++; end
    chk("abort_reached_grant", snoop_valid, 1);
    if (!in_grant) begin @(posedge clk); #1; end
    bus_request = '0;
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (mem_req || bus_done) bad++;
    end
    chk("abort_no_mem_no_done", bad, 0);
    chk("abort_grant_dropped", bus_grant, 0);
    sb.delete();
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   cyc;
    reset = 1'b1;
    bus_request = '0; bus_rw = '0; req_addr = '0; req_data = '0; snoop_hit = '0;
    ptr = N - 1;
    last_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero();
    reset = 1'b0;

    run_round(4'b0010, 1);
    run_round(4'b0100, 2);
    run_round(4'b1111, 1);
    run_round(4'b1111, 0);
    for (int r = 0; r < 30; r++) run_round(N'($urandom_range(1, 15)), $urandom_range(0, 3));

    abort_txn(3, 1'b0);
    run_round(4'b1111, 1);
    abort_txn(1, 1'b1);
    run_round(N'($urandom_range(1, 15)), 2);

    // Reset in the middle of a stalled memory access.
    e = '{owner: 2, rw: 0, addr: 32'h300, data: 0, rdata: 0, shared: 0, err: 0,
          abort: 0, b2b: 0};
    sb.push_back(e);
    mem_hold = 1'b1;
    bus_rw[2] = 1'b0;
    req_addr[2*AW +: AW] = e.addr;
    bus_request = 4'b0100;
    cyc = 0;
    while (!mem_req && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("reset_reached_mem", mem_req, 1);
    #2 reset = 1'b1;
    #1 check_all_zero();
    bus_request = '0;
    sb.delete();
    mem_hold = 1'b0;
    ptr = N - 1;
    last_rd = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    run_round(4'b1111, 1);

`ifdef SNOOP_ARB_TIMEOUT_EN
    begin
      int n_req;
      e = '{owner: 0, rw: 0, addr: 32'h400, data: 0, rdata: last_rd, shared: 0, err: 1,
            abort: 0, b2b: 0};
      e.owner = next_owner(4'b0001);
      ptr = e.owner;
      sb.push_back(e);
      mem_hold  = 1'b1;
      snoop_hit = '0;
      bus_rw[0] = 1'b0;
      req_addr[0 +: AW] = e.addr;
      bus_request = 4'b0001;
      n_req = 0;
      cyc   = 0;
      while (!bus_done && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
        if (mem_req) n_req++;
      end
      chk("timeout_done", bus_done, 1);
      chk("timeout_mem_req_cycles", n_req, MW);
      bus_request = '0;
      mem_hold = 1'b0;
    end
`endif

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
